// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one memory bus between instruction fetch (master 0)
// and load/store data (master 1).
//   - IDLE -> GRANTn -> IDLE per transfer, one transfer at a time.
//   - The loser of arbitration is stalled with waitrequest.
//   - Read data (one-cycle slave latency) is steered back to the issuing master.
// Optional feature macro: BUS_ARB_ROUND_ROBIN_EN.
//   - Defined: round-robin on ties, using last_grant.
//   - Undefined: fixed priority, master 1 wins ties.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   m0_*/m1_*              master request side (address/read/write/writedata/
//                          byteenable in; waitrequest/readdatavalid out)
//   readdata               slave read data, shared by both masters
//   s_*                    slave side (address/read/write/writedata/byteenable
//                          out; waitrequest/readdata in)
module mips_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic                m1_readdatavalid,
    output logic [DATA_W-1:0]   readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_rd_pending;
    logic   r_rd_owner;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic   r_last_grant;
`endif

    logic w_req0;
    logic w_req1;
    logic w_win;
    logic w_gnt_req;
    logic w_gnt_rd;
    logic w_accept;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Arbitration winner, meaningful only when at least one master requests
`ifdef BUS_ARB_ROUND_ROBIN_EN
    assign w_win = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
`else
    assign w_win = w_req1;
`endif

    // Request and read strobe of the currently granted master
    always_comb begin
        w_gnt_req = 1'b0;
        w_gnt_rd  = 1'b0;
        case (r_state)
            GRANT0: begin
                w_gnt_req = w_req0;
                w_gnt_rd  = m0_read;
            end
            GRANT1: begin
                w_gnt_req = w_req1;
                w_gnt_rd  = m1_read;
            end
            default: ;
        endcase
    end

    assign w_accept = w_gnt_req & ~s_waitrequest;

    // State, read-return tracking and grant history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_rd_pending <= w_accept & w_gnt_rd;
            if (w_accept & w_gnt_rd) begin
                r_rd_owner <= (r_state == GRANT1);
            end
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_state <= w_win ? GRANT1 : GRANT0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_win;
`endif
                    end
                end
                // Accept or a dropped request both end the grant
                GRANT0, GRANT1: begin
                    if (!w_gnt_req || !s_waitrequest) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Slave-side mux and master stalls follow the granted master directly
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = BE_W'(0);
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (r_state)
            GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    // Reset suppresses a return pulse that is already pending
    assign m0_readdatavalid = r_rd_pending & ~r_rd_owner & ~reset;
    assign m1_readdatavalid = r_rd_pending &  r_rd_owner & ~reset;
    assign readdata         = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
module tb_mips_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m1_read, m0_write, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [DATA_W-1:0] readdata;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;

    int n_cmp = 0;
    int n_err = 0;

    mips_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .readdata         (readdata),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".m0_wait"}, 64'(m0_waitrequest), 64'd1);
        chk({tag, ".m1_wait"}, 64'(m1_waitrequest), 64'd1);
        chk({tag, ".s_strb"},  64'({s_read, s_write}), 64'd0);
        chk({tag, ".s_addr"},  64'(s_address), 64'd0);
        chk({tag, ".s_wd"},    64'(s_writedata), 64'd0);
        chk({tag, ".s_be"},    64'(s_byteenable), 64'd0);
        chk({tag, ".rdv"},     64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);
    endtask

    logic exp_m1;
    logic [ADDR_W-1:0] exp_addr;

    initial begin
        reset = 1'b1;
        m0_address = '0; m1_address = '0;
        m0_read = 1'b0; m1_read = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
        m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;
        s_readdata = '0;

        // Reset for two cycles, then idle with no requests
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk_idle_outputs("rst");
        tick();
        chk_idle_outputs("rst_idle");

        // m0 single read, no slave wait
        m0_read = 1'b1; m0_address = 32'hBFC00000; s_waitrequest = 1'b0;
        settle();
        chk("rd0.c0_sread", 64'(s_read), 64'd0);
        chk("rd0.c0_m0wait", 64'(m0_waitrequest), 64'd1);
        tick();
        chk("rd0.c1_sread", 64'(s_read), 64'd1);
        chk("rd0.c1_saddr", 64'(s_address), 64'hBFC00000);
        chk("rd0.c1_m0wait", 64'(m0_waitrequest), 64'd0);
        chk("rd0.c1_m1wait", 64'(m1_waitrequest), 64'd1);
        tick();
        m0_read = 1'b0; s_readdata = 32'h3C08BFC0;
        settle();
        chk("rd0.c2_m0rdv", 64'(m0_readdatavalid), 64'd1);
        chk("rd0.c2_data", 64'(readdata), 64'h3C08BFC0);
        chk("rd0.c2_m1rdv", 64'(m1_readdatavalid), 64'd0);
        chk("rd0.c2_sread", 64'(s_read), 64'd0);
        tick();
        chk("rd0.c3_m0rdv", 64'(m0_readdatavalid), 64'd0);

        // m1 write stretched by three slave wait cycles
        m1_write = 1'b1; m1_address = 32'hBFC0002C;
        m1_writedata = 32'hFFFF0000; m1_byteenable = 4'b1111; s_waitrequest = 1'b1;
        settle();
        chk("wr1.c0_swrite", 64'(s_write), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("wr1.c%0d_swrite", c), 64'(s_write), 64'd1);
            chk($sformatf("wr1.c%0d_m1wait", c), 64'(m1_waitrequest), 64'd1);
        end
        chk("wr1.saddr", 64'(s_address), 64'hBFC0002C);
        chk("wr1.swd", 64'(s_writedata), 64'hFFFF0000);
        chk("wr1.sbe", 64'(s_byteenable), 64'hF);
        tick();
        s_waitrequest = 1'b0;
        settle();
        chk("wr1.c4_swrite", 64'(s_write), 64'd1);
        chk("wr1.c4_m1wait", 64'(m1_waitrequest), 64'd0);
        tick();
        m1_write = 1'b0;
        settle();
        chk("wr1.c5_swrite", 64'(s_write), 64'd0);
        chk("wr1.c5_m1wait", 64'(m1_waitrequest), 64'd1);
        chk("wr1.c5_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'd0);

        // Both masters read continuously for four transfers
        m0_read = 1'b1; m0_address = 32'h00000A00;
        m1_read = 1'b1; m1_address = 32'h00000B10;
        for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            exp_m1 = (i % 2) == 1;
`else
            exp_m1 = 1'b1;
`endif
            exp_addr = exp_m1 ? 32'h00000B10 : 32'h00000A00;
            tick();
            chk($sformatf("arb%0d.saddr", i), 64'(s_address), 64'(exp_addr));
            chk($sformatf("arb%0d.m0wait", i), 64'(m0_waitrequest), 64'(exp_m1));
            chk($sformatf("arb%0d.m1wait", i), 64'(m1_waitrequest), 64'(!exp_m1));
            tick();
            if (i == 3) begin
                m0_read = 1'b0; m1_read = 1'b0;
            end
            settle();
            chk($sformatf("arb%0d.idle_sread", i), 64'(s_read), 64'd0);
            chk($sformatf("arb%0d.rdv", i), 64'({m1_readdatavalid, m0_readdatavalid}),
                exp_m1 ? 64'd2 : 64'd1);
        end

        // m1 read accepted, reset in the return cycle drops the pulse
        tick();
        m1_read = 1'b1; m1_address = 32'h00001234; s_readdata = 32'hDEADBEEF;
        tick();
        chk("rst_rd.m1wait", 64'(m1_waitrequest), 64'd0);
        tick();
        m1_read = 1'b0; reset = 1'b1;
        settle();
        chk("rst_rd.m1rdv", 64'(m1_readdatavalid), 64'd0);
        tick();
        reset = 1'b0;
        settle();
        chk_idle_outputs("rst_rd.after");

        // After reset the first tie goes to m0 under round-robin, m1 otherwise
        m0_read = 1'b1; m0_address = 32'h00000A00;
        m1_read = 1'b1; m1_address = 32'h00000B10;
        tick();
`ifdef BUS_ARB_ROUND_ROBIN_EN
        chk("tie.saddr", 64'(s_address), 64'h00000A00);
`else
        chk("tie.saddr", 64'(s_address), 64'h00000B10);
`endif
        m0_read = 1'b0; m1_read = 1'b0;
        tick();
        tick();
        chk_idle_outputs("tie.idle");

        // m0 abandons its read while the slave is stalling
        m0_read = 1'b1; m0_address = 32'h00000C00; s_waitrequest = 1'b1;
        tick();
        chk("drop.sread", 64'(s_read), 64'd1);
        chk("drop.m0wait", 64'(m0_waitrequest), 64'd1);
        tick();
        m0_read = 1'b0;
        settle();
        chk("drop.sread_follow", 64'(s_read), 64'd0);
        tick();
        m1_write = 1'b1; m1_address = 32'h00000D00;
        settle();
        chk("drop.m0rdv", 64'(m0_readdatavalid), 64'd0);
        chk("drop.idle_swrite", 64'(s_write), 64'd0);
        tick();
        s_waitrequest = 1'b0;
        settle();
        chk("drop.g1_swrite", 64'(s_write), 64'd1);
        chk("drop.g1_saddr", 64'(s_address), 64'h00000D00);
        chk("drop.g1_m1wait", 64'(m1_waitrequest), 64'd0);
        tick();
        m1_write = 1'b0;
        settle();
        chk_idle_outputs("drop.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #20000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
